// File: rtl/dm_pipe.sv
// Byte-addressed data memory with a single-entry response buffer.
// Loads and stores are accepted in one cycle; the response is registered and
// held until the consumer takes it. Faulting requests leave memory untouched
// and bump a saturating fault counter.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no response held, rsp_valid = 0
// ST_FULL  | response held in r_rdata/r_err, rsp_valid = 1
module dm_pipe #(
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1,
    parameter int ALIGN_CHK = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [7:0]        err_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic              w_accept;
    logic              w_is_word;
    logic              w_is_half;
    logic              w_bad_type;
    logic              w_misalign;
    logic              w_fault;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_a0;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [7:0]        w_b0;
    logic [7:0]        w_b1;
    logic [7:0]        w_b2;
    logic [7:0]        w_b3;
    logic [31:0]       w_load_data;

    assign rsp_valid = (r_state == ST_FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_is_word  = (req_type == 3'd0);
    assign w_is_half  = (req_type == 3'd1) || (req_type == 3'd2);
    assign w_bad_type = (req_type > 3'd4);
    assign w_misalign = (ALIGN_CHK != 0) &&
                        ((w_is_half && req_addr[0]) ||
                         (w_is_word && (req_addr[1:0] != 2'b00)));
    assign w_fault    = w_bad_type || w_misalign;
    assign w_wr_en    = w_accept && req_we && !w_fault;

    // Byte lanes wrap naturally because the address width equals log2(DEPTH).
    assign w_a0 = req_addr;
    assign w_a1 = req_addr + ADDR_W'(1);
    assign w_a2 = req_addr + ADDR_W'(2);
    assign w_a3 = req_addr + ADDR_W'(3);

    assign w_b0 = r_mem[w_a0];
    assign w_b1 = r_mem[w_a1];
    assign w_b2 = r_mem[w_a2];
    assign w_b3 = r_mem[w_a3];

    // Little-endian load assembly with sign/zero extension by access type.
    always_comb begin
        w_load_data = 32'h0;
        case (req_type)
            3'd0:    w_load_data = {w_b3, w_b2, w_b1, w_b0};
            3'd1:    w_load_data = {{16{w_b1[7]}}, w_b1, w_b0};
            3'd2:    w_load_data = {16'h0, w_b1, w_b0};
            3'd3:    w_load_data = {{24{w_b0[7]}}, w_b0};
            3'd4:    w_load_data = {24'h0, w_b0};
            default: w_load_data = 32'h0;
        endcase
    end

    // Response buffer next-state: a new accept always refills the slot.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_accept)      w_state_nxt = ST_FULL;
                else if (rsp_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Response buffer state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_EMPTY;
        else       r_state <= w_state_nxt;
    end

    // Memory array: reset image per INIT_MODE, little-endian partial writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= (INIT_MODE != 0) ? 8'(i) : 8'h00;
            end
        end else if (w_wr_en) begin
            r_mem[w_a0] <= req_wdata[7:0];
            if (w_is_half || w_is_word) r_mem[w_a1] <= req_wdata[15:8];
            if (w_is_word) begin
                r_mem[w_a2] <= req_wdata[23:16];
                r_mem[w_a3] <= req_wdata[31:24];
            end
        end
    end

    // Capture response payload on accept; held otherwise so it stays stable under backpressure.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= (w_fault || req_we) ? 32'h0 : w_load_data;
            r_err   <= w_fault;
        end
    end

    // Saturating fault counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= 8'h00;
        end else if (w_accept && w_fault && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'h01;
        end
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dm_pipe.sv
// Self-checking bench for dm_pipe. Instance 0 has alignment checking, instance 1
// does not. A transaction-level model (byte array + fault counter) predicts
// every response.
module tb_dm_pipe;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_we;
    logic [4:0]  req_addr  [2];
    logic [2:0]  req_type  [2];
    logic [31:0] req_wdata [2];
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata [2];
    logic [1:0]  rsp_err;
    logic [7:0]  err_cnt   [2];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem_m [2][32];
    int         err_m [2];

    always #5 clk = ~clk;

    dm_pipe #(.ADDR_W(5), .INIT_MODE(1), .ALIGN_CHK(1)) u_dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_type(req_type[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .err_cnt(err_cnt[0])
    );

    dm_pipe #(.ADDR_W(5), .INIT_MODE(1), .ALIGN_CHK(0)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_type(req_type[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .err_cnt(err_cnt[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 32; i++) mem_m[d][i] = 8'(i);
            err_m[d] = 0;
        end
    endfunction

    // Transaction-level reference: access size from type, fault rules, little-endian bytes.
    function automatic void model(input int d, input int we, input int addr, input int typ,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic err);
        int          size;
        bit          fault;
        logic [31:0] v;
        size  = (typ == 0) ? 4 : ((typ == 1 || typ == 2) ? 2 : 1);
        fault = (typ > 4) ||
                (d == 0 && ((size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0)));
        rd  = 32'h0;
        err = fault;
        if (fault) begin
            if (err_m[d] < 255) err_m[d]++;
        end else if (we != 0) begin
            for (int k = 0; k < size; k++) mem_m[d][(addr + k) % 32] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < size; k++) v = v | (32'(mem_m[d][(addr + k) % 32]) << (8 * k));
            if (typ == 1 && v[15]) v = v | 32'hFFFF0000;
            if (typ == 3 && v[7])  v = v | 32'hFFFFFF00;
            rd = v;
        end
    endfunction

    task automatic drive(input int d, input int we, input int addr, input int typ, input logic [31:0] wd);
        req_valid[1-d] = 1'b0;
        req_valid[d]   = 1'b1;
        req_we[d]      = (we != 0);
        req_addr[d]    = 5'(addr);
        req_type[d]    = 3'(typ);
        req_wdata[d]   = wd;
    endtask

    // One accepted request with immediate consumption; callable back-to-back.
    task automatic send(input int d, input int we, input int addr, input int typ,
                        input logic [31:0] wd, output logic [31:0] obs);
        logic [31:0] er;
        logic        ee;
        drive(d, we, addr, typ, wd);
        rsp_ready = 2'b11;
        #1;
        chk("req_ready", 32'(req_ready[d]), 32'd1);
        model(d, we, addr, typ, wd, er, ee);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
        chk("rsp_rdata", rsp_rdata[d], er);
        chk("rsp_err",   32'(rsp_err[d]), 32'(ee));
        chk("err_cnt",   32'(err_cnt[d]), 32'(err_m[d]));
        obs = rsp_rdata[d];
    endtask

    task automatic idle();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        chk("idle_rsp_valid0", 32'(rsp_valid[0]), 32'd0);
        chk("idle_rsp_valid1", 32'(rsp_valid[1]), 32'd0);
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("rst_rsp_err",   32'(rsp_err[d]), 32'd0);
            chk("rst_err_cnt",   32'(err_cnt[d]), 32'd0);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("post_rst_ready0", 32'(req_ready[0]), 32'd1);
        chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] er1, er2;
        logic        ee1, ee2;
        int          n_acc, n_rsp;

        req_valid = 2'b00;
        req_we    = 2'b00;
        rsp_ready = 2'b11;
        for (int d = 0; d < 2; d++) begin
            req_addr[d]  = 5'd0;
            req_type[d]  = 3'd0;
            req_wdata[d] = 32'h0;
        end
        do_reset();

        // Reset image reads
        send(0, 0, 4, 0, 32'h0, obs);  chk("lw@4",  obs, 32'h07060504);
        send(0, 0, 31, 3, 32'h0, obs); chk("lb@31", obs, 32'h0000001F);
        send(0, 0, 6, 1, 32'h0, obs);  chk("lh@6",  obs, 32'h00000706);
        idle();

        // Store followed by back-to-back sub-word loads
        send(0, 1, 8, 0, 32'hDEADBEEF, obs);
        send(0, 0, 11, 3, 32'h0, obs); chk("lb@11",  obs, 32'hFFFFFFDE);
        send(0, 0, 11, 4, 32'h0, obs); chk("lbu@11", obs, 32'h000000DE);
        send(0, 0, 8, 1, 32'h0, obs);  chk("lh@8",   obs, 32'hFFFFBEEF);
        send(0, 0, 10, 2, 32'h0, obs); chk("lhu@10", obs, 32'h0000DEAD);
        idle();

        // Alignment faults and counter saturation
        do_reset();
        send(0, 0, 3, 1, 32'h0, obs);
        chk("lh@3_rdata", obs, 32'h0);
        chk("lh@3_err",   32'(rsp_err[0]), 32'd1);
        chk("lh@3_cnt",   32'(err_cnt[0]), 32'd1);
        send(0, 1, 2, 0, 32'h55555555, obs);
        chk("sw@2_err", 32'(rsp_err[0]), 32'd1);
        chk("sw@2_cnt", 32'(err_cnt[0]), 32'd2);
        send(0, 0, 0, 0, 32'h0, obs);  chk("lw@0_after_fault", obs, 32'h03020100);
        for (int i = 0; i < 300; i++) send(0, i % 2, $urandom_range(0, 31), 5 + (i % 3), $urandom, obs);
        chk("err_cnt_sat", 32'(err_cnt[0]), 32'd255);
        idle();

        // Wrap-around on the unchecked instance
        send(1, 0, 30, 0, 32'h0, obs);     chk("lw@30_wrap", obs, 32'h01001F1E);
        send(1, 1, 31, 1, 32'h0000ABCD, obs);
        send(1, 0, 31, 4, 32'h0, obs);     chk("lbu@31", obs, 32'h000000CD);
        send(1, 0, 0, 4, 32'h0, obs);      chk("lbu@0",  obs, 32'h000000AB);
        idle();

        // Backpressure: pending load held for 3 cycles, second request waits
        drive(0, 0, 4, 0, 32'h0);
        rsp_ready[0] = 1'b0;
        model(0, 0, 4, 0, 32'h0, er1, ee1);
        @(posedge clk); #1;
        chk("bp_first_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_first_rdata", rsp_rdata[0], er1);
        drive(0, 0, 0, 3, 32'h0);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_hold_rdata", rsp_rdata[0], er1);
            chk("bp_hold_err",   32'(rsp_err[0]), 32'(ee1));
        end
        rsp_ready[0] = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready[0]), 32'd1);
        model(0, 0, 0, 3, 32'h0, er2, ee2);
        @(posedge clk); #1;
        chk("bp_second_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_second_rdata", rsp_rdata[0], er2);

        // Full throughput: 10 consecutive accepts and responses
        n_acc = 0;
        n_rsp = 0;
        for (int c = 0; c < 10; c++) begin
            int a;
            a = $urandom_range(0, 31);
            drive(0, 0, a, 4, 32'h0);
            #1;
            if (req_valid[0] && req_ready[0]) n_acc++;
            model(0, 0, a, 4, 32'h0, er1, ee1);
            @(posedge clk); #1;
            if (rsp_valid[0] && rsp_ready[0]) n_rsp++;
            chk("tp_rdata", rsp_rdata[0], er1);
        end
        chk("tp_accepts",   32'(n_acc), 32'd10);
        chk("tp_responses", 32'(n_rsp), 32'd10);
        idle();

        // Reset mid-stream with a pending response and a store presented
        drive(0, 0, 8, 0, 32'h0);
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        chk("mid_pending", 32'(rsp_valid[0]), 32'd1);
        drive(0, 1, 8, 0, 32'h11223344);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[0]), 32'd0);
        chk("mid_rst_rdata", rsp_rdata[0], 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_valid_hold", 32'(rsp_valid[0]), 32'd0);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        @(posedge clk); #1;
        send(0, 0, 8, 0, 32'h0, obs);  chk("lw@8_after_rst", obs, 32'h0B0A0908);
        idle();

        // Randomized mixed traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle();
            else send($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31),
                      $urandom_range(0, 7), $urandom, obs);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_pipe.md
DM_PIPE -- requirements
Module: dm_pipe

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width; DEPTH = 2^ADDR_W bytes.
REQ-002 SHALL have parameter INIT_MODE, default 1; 1 = byte i reset to i[7:0], 0 = all bytes reset to 0.
REQ-003 SHALL have parameter ALIGN_CHK, default 1; 1 = misaligned halfword/word access faults, 0 = allowed, with byte addresses wrapping modulo DEPTH.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  in  1  request present.
REQ-007 SHALL have port req_ready  out  1  request can be accepted.
REQ-008 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port req_type  in  3  0 word, 1 half, 2 half unsigned, 3 byte, 4 byte unsigned.
REQ-011 SHALL have port req_wdata  in  32  store data; low bytes used for half/byte.
REQ-012 SHALL have port rsp_valid  out  1  response present.
REQ-013 SHALL have port rsp_ready  in  1  consumer takes the response.
REQ-014 SHALL have port rsp_rdata  out  32  load data (0 for stores and errors).
REQ-015 SHALL have port rsp_err  out  1  request faulted.
REQ-016 SHALL have port err_cnt  out  8  saturating fault counter.

Function
REQ-017 SHALL accept a request on a rising edge when req_valid && req_ready.
REQ-018 SHALL drive req_ready = !rsp_valid || rsp_ready, combinationally, giving single-entry output buffering with full throughput.
REQ-019 SHALL use a two-state response FSM. EMPTY goes to FULL on accept. FULL stays FULL on accept && rsp_ready. FULL goes to EMPTY on rsp_ready && !accept. FULL otherwise holds.
REQ-020 SHALL present a response one cycle after accept: rsp_valid=1 with rsp_rdata and rsp_err. These SHALL be held stable while rsp_valid && !rsp_ready.
REQ-021 SHALL treat a request as a fault if req_type > 4. With ALIGN_CHK=1, it SHALL also fault on a half access with addr[0] != 0 or a word access with addr[1:0] != 0.
REQ-022 SHALL, on an accepted store without fault, write bytes little-endian at the accept edge: byte addr <- wdata[7:0]; half adds addr+1 <- [15:8]; word adds addr+2 <- [23:16] and addr+3 <- [31:24]. Addresses SHALL be computed modulo DEPTH.
REQ-023 SHALL, on an accepted load without fault, sample memory at the accept edge, little-endian. Byte and half loads SHALL sign-extend for types 1 and 3 and zero-extend for types 2 and 4.
REQ-024 SHALL make a load accepted in the cycle after a store return the stored data; there is no stale read.
REQ-025 SHALL, on a fault, leave memory unchanged, return rsp_rdata=0 and rsp_err=1, and increment err_cnt, saturating at 255.
REQ-026 SHALL give store responses rsp_rdata=0 and rsp_err=0.
REQ-027 SHALL ignore req_we, req_addr, req_type and req_wdata when there is no accept.

Reset
REQ-028 SHALL, while rstn=0 and independent of clk, set rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, and set memory per INIT_MODE.
REQ-029 SHALL discard any in-flight request or pending response on reset. No write SHALL occur in a cycle where rstn=0.
REQ-030 SHALL drive req_ready=1 after reset release.

Verification
REQ-031 Defaults, after reset: lw@4 -> 0x07060504; lb@31 -> 0x0000001F; lh@6 -> 0x00000706. Each response SHALL arrive one cycle after accept, with rsp_err=0.
REQ-032 sw 0xDEADBEEF@8, then back-to-back lb@11 -> 0xFFFFFFDE, lbu@11 -> 0x000000DE, lh@8 -> 0xFFFFBEEF, lhu@10 -> 0x0000DEAD.
REQ-033 ALIGN_CHK=1: lh@3 -> rsp_err=1, rdata=0, err_cnt=1. Then sw@2 -> err, err_cnt=2, lw@0 still 0x03020100. After 300 faults, err_cnt=255.
REQ-034 ALIGN_CHK=0: lw@30 -> 0x01001F1E (wrap). sh 0xABCD@31, then lbu@31 -> 0xCD and lbu@0 -> 0xAB.
REQ-035 Backpressure: hold rsp_ready=0 for 3 cycles with a pending load. rsp_valid, rsp_rdata and rsp_err SHALL stay stable, req_ready=0, and no second accept SHALL occur. With req_valid=1 and rsp_ready=1 held for 10 cycles, there SHALL be 10 accepts and 10 responses.
REQ-036 Assert rstn=0 mid-stream, with a pending response and a store presented. rsp_valid SHALL drop immediately, the store SHALL not land, and lw@8 after release SHALL return 0x0B0A0908.
